// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Stalls the upstream pipeline while a divide is in flight and delivers LO (quotient) / HI (remainder).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    counter;
  logic             q_neg;
  logic             r_neg;

  logic             can_accept;
  logic             div_zero;
  logic             last_step;
  logic             no_borrow;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  assign can_accept = ((state == IDLE) || (state == DONE)) && start && !cancel;
  assign div_zero   = (b == '0);
  assign last_step  = (counter == CW'(WIDTH - 1));
  assign stall      = (can_accept && !div_zero) || ((state == BUSY) && !cancel);

  assign abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_div && b[WIDTH-1]) ? -b : b;

  // A set shifted-out MSB means the partial remainder already exceeds any WIDTH-bit divisor.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign trial     = {1'b0, rem_shift[WIDTH-1:0]} - {1'b0, divisor};
  assign no_borrow = rem_shift[WIDTH] || !trial[WIDTH];
  assign quo_shift = {quo[WIDTH-2:0], no_borrow};
  assign rem_next  = no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_final = q_neg ? -quo_shift : quo_shift;
  assign rem_final = r_neg ? -rem_next : rem_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (cancel) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_next = div_zero ? DONE : BUSY;
          end else begin
            state_next = IDLE;
          end
        end
        BUSY: begin
          if (last_step) begin
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready   <= 1'b0;
      lo      <= '0;
      hi      <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      counter <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (cancel) begin
        counter <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              counter <= '0;
              if (div_zero) begin
                hi    <= a;
                lo    <= '1;
                ready <= 1'b1;
              end else begin
                rem     <= '0;
                quo     <= abs_a;
                divisor <= abs_b;
                q_neg   <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg   <= signed_div && a[WIDTH-1];
              end
            end
          end
          BUSY: begin
            rem     <= rem_next;
            quo     <= quo_shift;
            counter <= counter + CW'(1);
            if (last_step) begin
              lo      <= quo_final;
              hi      <= rem_final;
              ready   <= 1'b1;
              counter <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed ops, scoreboard of expected {lo,hi},
// latency/stall counting, divide-by-zero, cancel, back-to-back and mid-op reset.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        ready;
  logic [31:0] lo;
  logic [31:0] hi;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_div(signed_div),
    .cancel    (cancel),
    .a         (a),
    .b         (b),
    .stall     (stall),
    .ready     (ready),
    .lo        (lo),
    .hi        (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result packed as {lo, hi}.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (!s) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sx = x;
    sy = y;
    sq = sx / sy;
    sr = sx % sy;
    return {sq, sr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input bit push);
    start      = 1'b1;
    a          = x;
    b          = y;
    signed_div = s;
    if (push) sb_q.push_back(model(x, y, s));
  endtask

  // Called in the cycle where start is driven; returns in the ready cycle.
  task automatic wait_done(input string tag, input int exp_cyc, input int exp_stall);
    int cyc;
    int sc;
    logic [63:0] exp;
    cyc = 0;
    sc  = 0;
    #1;
    if (stall) sc++;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      #1;
      if (stall) sc++;
    end while (!ready && cyc < 100);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_stall_cycles"}, 32'(sc), 32'(exp_stall));
    check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_lo"}, lo, exp[63:32]);
      check({tag, "_hi"}, hi, exp[31:0]);
      last_lo = exp[63:32];
      last_hi = exp[31:0];
    end
  endtask

  initial begin
    int rdy_seen;
    reset      = 1'b0;
    start      = 1'b0;
    cancel     = 1'b0;
    signed_div = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    last_lo    = 32'd0;
    last_hi    = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_hi", hi, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk); issue(32'd100, 32'd7, 1'b0, 1'b1); wait_done("divu_100_7", 33, 33);
    @(negedge clk); #1;
    check("ready_single_pulse", {31'd0, ready}, 32'd0);

    @(negedge clk); issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1); wait_done("div_m7_2", 33, 33);
    @(negedge clk); issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1); wait_done("div_7_m2", 33, 33);
    @(negedge clk); issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done("div_overflow", 33, 33);
    @(negedge clk); issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1); wait_done("divu_max_1", 33, 33);
    @(negedge clk); issue(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1); wait_done("divu_big_div", 33, 33);
    @(negedge clk); issue(32'h0000_1234, 32'd0, 1'b0, 1'b1); wait_done("divu_zero", 1, 0);

    // Cancel in BUSY cycle 10: no result, lo/hi retained.
    @(negedge clk); issue(32'd100, 32'd7, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_stall_drop", {31'd0, stall}, 32'd0);
    rdy_seen = 0;
    @(negedge clk);
    cancel = 1'b0;
    repeat (40) begin
      #1;
      if (ready) rdy_seen++;
      @(negedge clk);
    end
    #1;
    check("cancel_no_ready", 32'(rdy_seen), 32'd0);
    check("cancel_idle_stall", {31'd0, stall}, 32'd0);
    check("cancel_lo_kept", lo, last_lo);
    check("cancel_hi_kept", hi, last_hi);

    @(negedge clk); issue(32'd9, 32'd3, 1'b0, 1'b1); wait_done("divu_9_3", 33, 33);

    // Back-to-back: second request issued in the ready cycle of the first.
    @(negedge clk); issue(32'd100, 32'd7, 1'b0, 1'b1); wait_done("b2b_first", 33, 33);
    issue(32'd50, 32'd5, 1'b0, 1'b1); wait_done("b2b_second", 33, 33);

    // Reset asserted mid-BUSY.
    @(negedge clk); issue(32'd50, 32'd7, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_lo", lo, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_ready", {31'd0, ready}, 32'd0);
    check("midreset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); reset = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (ready) rdy_seen++;
    end
    check("midreset_no_ready", 32'(rdy_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
